// File: rtl/display_scan_ctrl.sv
// Multiplexed four-digit display scanner with double-buffered data.
// New data is committed only between frames so a frame never tears.
module display_scan_ctrl #(
    parameter int DIV   = 4,
    parameter int GUARD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  blank,
    output logic [3:0]  seg_bin,
    output logic [3:0]  digit_en,
    output logic        load_ack,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_GUARD,
        ST_SHOW
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] GUARD_LAST = (GUARD > 0) ? 16'(GUARD - 1) : 16'd0;

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic        pending;
    logic [15:0] pend_data;
    logic [3:0]  pend_blank;
    logic [15:0] act_data;
    logic [3:0]  act_blank;

    logic        commit;
    logic        slot_start;
    logic [1:0]  next_idx;
    logic [15:0] src_data;
    logic [3:0]  src_blank;

    function automatic logic [3:0] nib(input logic [15:0] d, input logic [1:0] i);
        return d[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sel(input logic [3:0] b, input logic [1:0] i);
        return b[i] ? 4'b0000 : (4'b0001 << i);
    endfunction

    // A new slot begins either on commit from OFF or at the end of a SHOW.
    always_comb begin
        commit     = 1'b0;
        slot_start = 1'b0;
        next_idx   = idx;
        case (state)
            ST_OFF: begin
                if (pending) begin
                    commit     = 1'b1;
                    slot_start = 1'b1;
                    next_idx   = 2'd0;
                end
            end
            ST_SHOW: begin
                if (cnt == DIV_LAST) begin
                    slot_start = 1'b1;
                    next_idx   = idx + 2'd1;
                    commit     = pending && (idx == 2'd3);
                end
            end
            default: ;
        endcase
        src_data  = commit ? pend_data  : act_data;
        src_blank = commit ? pend_blank : act_blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= 16'd0;
            idx         <= 2'd0;
            pending     <= 1'b0;
            pend_data   <= 16'd0;
            pend_blank  <= 4'd0;
            act_data    <= 16'd0;
            act_blank   <= 4'd0;
            seg_bin     <= 4'd0;
            digit_en    <= 4'd0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            if (slot_start) begin
                idx         <= next_idx;
                cnt         <= 16'd0;
                seg_bin     <= nib(src_data, next_idx);
                frame_start <= (next_idx == 2'd0);
                load_ack    <= commit;
                if (commit) begin
                    act_data  <= pend_data;
                    act_blank <= pend_blank;
                    pending   <= 1'b0;
                end
                if (GUARD == 0) begin
                    state    <= ST_SHOW;
                    digit_en <= sel(src_blank, next_idx);
                end else begin
                    state    <= ST_GUARD;
                    digit_en <= 4'd0;
                end
            end else if (state == ST_GUARD) begin
                if (cnt == GUARD_LAST) begin
                    state    <= ST_SHOW;
                    cnt      <= 16'd0;
                    digit_en <= sel(act_blank, idx);
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else if (state == ST_SHOW) begin
                cnt <= cnt + 16'd1;
            end
            // A load on a commit edge lands in pend after the old pend moved on.
            if (load) begin
                pend_data  <= data;
                pend_blank <= blank;
                pending    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl using a frame-timeline model.
// Expected outputs are queued per edge and compared at the falling edge.
module tb_display_scan_ctrl;

    localparam int D = 4;
    localparam int G = 1;
    localparam int P = 4 * (G + D);

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  seg_bin;
    logic [3:0]  digit_en;
    logic        load_ack;
    logic        frame_start;

    display_scan_ctrl #(.DIV(D), .GUARD(G)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .data(data),
        .blank(blank),
        .seg_bin(seg_bin),
        .digit_en(digit_en),
        .load_ack(load_ack),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb_q[$];

    bit          m_run;
    int          m_t;
    bit          m_pending;
    bit          m_ack;
    logic [15:0] m_pend_d;
    logic [3:0]  m_pend_b;
    logic [15:0] m_act_d;
    logic [3:0]  m_act_b;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run     = 0;
        m_t       = 0;
        m_pending = 0;
        m_ack     = 0;
        m_pend_d  = 16'd0;
        m_pend_b  = 4'd0;
        m_act_d   = 16'd0;
        m_act_b   = 4'd0;
    endtask

    task automatic model_commit();
        m_act_d   = m_pend_d;
        m_act_b   = m_pend_b;
        m_pending = 0;
        m_ack     = 1;
    endtask

    task automatic model_edge(input logic l, input logic [15:0] d, input logic [3:0] b);
        m_ack = 0;
        if (!m_run) begin
            if (m_pending) begin
                m_run = 1;
                m_t   = 0;
                model_commit();
            end
        end else begin
            m_t++;
            if ((m_t % P) == 0 && m_pending) model_commit();
        end
        if (l) begin
            m_pend_d  = d;
            m_pend_b  = b;
            m_pending = 1;
        end
    endtask

    function automatic logic [9:0] model_out();
        int pos, slot, w;
        logic [3:0] seg, en;
        if (!m_run) return 10'd0;
        pos  = m_t % P;
        slot = pos / (G + D);
        w    = pos % (G + D);
        seg  = 4'((m_act_d >> (4 * slot)) & 16'hF);
        en   = (w < G || m_act_b[slot]) ? 4'b0000 : 4'(1 << slot);
        return {seg, en, m_ack, (pos == 0)};
    endfunction

    // Drive one cycle; the model follows the edge only while out of reset.
    task automatic step(input logic l, input logic [15:0] d, input logic [3:0] b);
        load  = l;
        data  = d;
        blank = b;
        @(posedge clk);
        if (rst_n) model_edge(l, d, b);
        sb_q.push_back(model_out());
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 4'd0);
    endtask

    function automatic bit in_show_slot(input int s);
        int pos;
        if (!m_run) return 0;
        pos = m_t % P;
        return (pos / (G + D)) == s && (pos % (G + D)) >= G;
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) chk("cycle", {seg_bin, digit_en, load_ack, frame_start}, sb_q.pop_front());
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        data  = 16'd0;
        blank = 4'd0;
        model_reset();
        #2;
        chk("reset_out", {seg_bin, digit_en, load_ack, frame_start}, 10'd0);
        idle(2);
        // load coincides with an edge while reset is still low
        step(1'b1, 16'hDEAD, 4'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(100);

        step(1'b1, 16'h1A3F, 4'b0000);
        idle(2 * P + 3);

        step(1'b1, 16'h1234, 4'b0101);
        idle(2 * P + 3);

        for (int i = 0; i < P && !in_show_slot(2); i++) step(1'b0, 16'd0, 4'd0);
        step(1'b1, 16'hBEEF, 4'b0000);
        idle(2 * P);

        step(1'b1, 16'h1111, 4'b0000);
        idle(3);
        step(1'b1, 16'h2222, 4'b0000);
        idle(2 * P);

        step(1'b1, 16'h5555, 4'b0000);
        for (int i = 0; i < P && ((m_t + 1) % P) != 0; i++) step(1'b0, 16'd0, 4'd0);
        step(1'b1, 16'h6666, 4'b0010);
        idle(2 * P + 2);

        for (int i = 0; i < P && !in_show_slot(2); i++) step(1'b0, 16'd0, 4'd0);
        chk("pre_rst_digit2", {6'd0, digit_en}, 10'b0100);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {seg_bin, digit_en, load_ack, frame_start}, 10'd0);
        model_reset();
        idle(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(30);

        step(1'b1, 16'hC0DE, 4'b1000);
        idle(P + 3);

        @(negedge clk);
        #1;
        chk("queue_drained", 10'(sb_q.size()), 10'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
